// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the matrix scanner:
// FSM encoding, LFSR constants and the key-code to row/column mapping.
package teclado_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } estado_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form: taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

  // Feedback bit; it is also bit 0 of the next LFSR value.
  function automatic logic lfsr_fb(input logic [7:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], lfsr_fb(q)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the contact-bounce source.
module lfsr8
  import teclado_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= LFSR_SEED;
    else      q <= lfsr_step(q);
  end

endmodule

// File: rtl/emulador_teclado.sv
// 4x4 keypad emulator: answers the scanner's column drive with row sense for
// one commanded key, with LFSR contact bounce around a timed firm closure.
module emulador_teclado
  import teclado_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 8,
  parameter int RELEASE_GAP   = 16,
  parameter int HOLD_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        saida_conf_teclado,
  output logic [3:0]        entrada_teclado,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done
);

  localparam int CW_B  = $clog2(BOUNCE_CYCLES + 1);
  localparam int CW_G  = $clog2(RELEASE_GAP + 1);
  localparam int CW_BG = (CW_B > CW_G) ? CW_B : CW_G;
  localparam int CW    = (HOLD_W > CW_BG) ? HOLD_W : CW_BG;

  // Counter holds "cycles left minus one" so a phase ends when it reads zero.
  localparam logic [CW-1:0] BOUNCE_LOAD = (BOUNCE_CYCLES > 0) ? CW'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] GAP_LOAD    = (RELEASE_GAP > 0)   ? CW'(RELEASE_GAP - 1)   : '0;

  estado_t           r_state;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_key;
  logic [HOLD_W-1:0] r_hold;
  logic              r_contact;
  logic              r_done;

  estado_t           w_next;
  logic [CW-1:0]     w_load;
  logic [HOLD_W-1:0] w_hold_src;
  logic [CW-1:0]     w_hold_load;
  logic              w_cnt_zero;
  logic              w_accept;
  logic              w_contact_next;
  logic [7:0]        w_lfsr;
  logic              w_bounce_bit;
  logic [1:0]        w_row;
  logic [1:0]        w_col;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Contact is registered, so it takes the LFSR bit the LFSR itself will hold next cycle.
  assign w_bounce_bit = lfsr_fb(w_lfsr);
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
  assign w_hold_src   = (r_state == ST_IDLE) ? cmd_hold : r_hold;
  assign w_hold_load  = (w_hold_src == '0) ? '0 : CW'(w_hold_src - HOLD_W'(1));

  // State register, phase counter, command latch and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_key     <= '0;
      r_hold    <= '0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_contact <= w_contact_next;
      r_done    <= (r_state == ST_GAP) && (w_next == ST_IDLE);
      if (w_accept) begin
        r_key  <= cmd_key;
        r_hold <= cmd_hold;
      end
      if (w_next != r_state) r_cnt <= w_load;
      else if (!w_cnt_zero)  r_cnt <= r_cnt - CW'(1);
    end
  end

  // Next-state logic; abort beats a same-edge phase exit everywhere but GAP
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_next = (BOUNCE_CYCLES > 0) ? ST_BOUNCE_IN : ST_HOLD;
      end
      ST_BOUNCE_IN: begin
        if (cmd_abort)       w_next = ST_GAP;
        else if (w_cnt_zero) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (cmd_abort)       w_next = ST_GAP;
        else if (w_cnt_zero) w_next = (BOUNCE_CYCLES > 0) ? ST_BOUNCE_OUT : ST_GAP;
      end
      ST_BOUNCE_OUT: begin
        if (cmd_abort || w_cnt_zero) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_cnt_zero) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counter reload and contact value for the phase being entered
  always_comb begin
    w_load         = '0;
    w_contact_next = 1'b0;
    unique case (w_next)
      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        w_load         = BOUNCE_LOAD;
        w_contact_next = w_bounce_bit;
      end
      ST_HOLD: begin
        w_load         = w_hold_load;
        w_contact_next = 1'b1;
      end
      ST_GAP:  w_load = GAP_LOAD;
      default: w_load = '0;
    endcase
  end

  // Outputs; row sense is purely combinational on the live column drive
  assign w_row = key_row(r_key);
  assign w_col = key_col(r_key);

  always_comb begin
    cmd_ready       = (r_state == ST_IDLE);
    busy            = (r_state != ST_IDLE);
    done            = r_done;
    entrada_teclado = 4'b1111;
    if (r_contact && !saida_conf_teclado[w_col]) entrada_teclado[w_row] = 1'b0;
  end

endmodule

// File: tb/tb_emulador_teclado.sv
// Directed bench for emulador_teclado: row-sense model with reference LFSR and
// a done-time scoreboard filled at accept/abort and drained by a done monitor.
module tb_emulador_teclado;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cols, rows, cols0, rows0;
  logic        cv, cr, ca, busy, done;
  logic [3:0]  ck;
  logic [15:0] ch;
  logic        cv0, cr0, ca0, busy0, done0;
  logic [3:0]  ck0;
  logic [15:0] ch0;

  always #5 clk = ~clk;

  emulador_teclado #(.BOUNCE_CYCLES(8), .RELEASE_GAP(16), .HOLD_W(16)) dut (
    .clk(clk), .rst(rst), .saida_conf_teclado(cols), .entrada_teclado(rows),
    .cmd_valid(cv), .cmd_ready(cr), .cmd_key(ck), .cmd_hold(ch),
    .cmd_abort(ca), .busy(busy), .done(done)
  );

  emulador_teclado #(.BOUNCE_CYCLES(0), .RELEASE_GAP(16), .HOLD_W(16)) dut0 (
    .clk(clk), .rst(rst), .saida_conf_teclado(cols0), .entrada_teclado(rows0),
    .cmd_valid(cv0), .cmd_ready(cr0), .cmd_key(ck0), .cmd_hold(ch0),
    .cmd_abort(ca0), .busy(busy0), .done(done0)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int q_done[$];
  int q_done0[$];
  logic [7:0] m_lfsr;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference x^8+x^6+x^5+x^4+1 sequence, same reset as the DUT
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected contact k cycles after accept, bounce length 8, firm hold h
  function automatic logic cexp(input int k, input int h, input logic lb);
    if (k < 8)      return lb;
    if (k < 8 + h)  return 1'b1;
    if (k < 16 + h) return lb;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (q_done.size() == 0) chk("done_spurious", 32'(q_done.size()), 32'd1);
      else                    chk("done_time", 32'(cyc), 32'(q_done.pop_front()));
    end
    if (rst === 1'b1 && done0 === 1'b1) begin
      if (q_done0.size() == 0) chk("done0_spurious", 32'(q_done0.size()), 32'd1);
      else                     chk("done0_time", 32'(cyc), 32'(q_done0.pop_front()));
    end
  end

  initial begin
    int n, n2;
    logic c;
    logic [3:0] e;
    logic [3:0] onehot;

    rst = 1'b0; cv = 0; ca = 0; ck = '0; ch = '0; cols = 4'hF;
    cv0 = 0; ca0 = 0; ck0 = '0; ch0 = '0; cols0 = 4'hF;

    // Reset values under random column drive
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cols = 4'($urandom); cols0 = 4'($urandom); cv = 1'b1; ck = 4'($urandom);
      #1;
      chk("rst_rows", 32'(rows), 32'hF);
      chk("rst_ready", 32'(cr), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rows0", 32'(rows0), 32'hF);
    end
    @(negedge clk);
    cv = 0; ck = '0; cols0 = 4'b1011; cols = 4'b1110;
    rst = 1'b1;

    // Clean press without bounce: key 6 (row 1, col 2), hold 20
    @(negedge clk);
    ck0 = 4'h6; ch0 = 16'd20; cv0 = 1'b1;
    @(posedge clk); #1;
    n = cyc; cv0 = 0; ck0 = '0; ch0 = '0;
    q_done0.push_back(n + 36);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      chk("clean_rows", 32'(rows0), (k < 20) ? 32'hD : 32'hF);
      chk("clean_busy", 32'(busy0), (k < 36) ? 32'd1 : 32'd0);
    end

    // Key F, hold 10, rotating single-column scan
    @(negedge clk);
    ck = 4'hF; ch = 16'd10; cv = 1'b1;
    @(posedge clk); #1;
    n = cyc; cv = 0; ck = '0; ch = '0;
    q_done.push_back(n + 42);
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      onehot = 4'b0001 << (k % 4);
      cols = ~onehot;
      #1;
      c = cexp(k, 10, m_lfsr[0]);
      e = {~(c & ~cols[3]), 3'b111};
      chk("sel_rows", 32'(rows), 32'(e));
    end

    // Abort in HOLD cycle 5: key 0, hold 100; valid during GAP must be ignored
    @(negedge clk);
    cols = 4'b1110; ck = 4'h0; ch = 16'd100; cv = 1'b1;
    @(posedge clk); #1;
    n = cyc; cv = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk); #1;
      c = (k <= 12) ? cexp(k, 100, m_lfsr[0]) : 1'b0;
      chk("abort_rows", 32'(rows), 32'({3'b111, ~c}));
      if (k >= 13 && k <= 28) chk("abort_ready", 32'(cr), 32'd0);
      if (k >= 29) chk("abort_busy", 32'(busy), 32'd0);
      if (k == 12) begin ca = 1'b1; q_done.push_back(n + 29); end
      if (k == 13) begin ca = 1'b0; cv = 1'b1; ck = 4'h3; ch = 16'd5; end
      if (k == 27) cv = 1'b0;
    end

    // Back-to-back, hold 0, all columns low: full contact pattern visible on row 0
    @(negedge clk);
    cols = 4'b0000; ck = 4'h1; ch = 16'd0; cv = 1'b1;
    @(posedge clk); #1;
    n = cyc; cv = 0;
    q_done.push_back(n + 33);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk); #1;
      c = cexp(k, 1, m_lfsr[0]);
      chk("b2b1_rows", 32'(rows), 32'({3'b111, ~c}));
      if (k == 33) begin
        chk("b2b_done_ready", 32'({done, cr}), 32'b11);
        ck = 4'h2; ch = 16'd0; cv = 1'b1;
      end
    end
    @(posedge clk); #1;
    n2 = cyc; cv = 0;
    chk("b2b_accept", 32'(busy), 32'd1);
    chk("b2b_gap", 32'(n2 - n), 32'd34);
    q_done.push_back(n2 + 33);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk); #1;
      c = cexp(k, 1, m_lfsr[0]);
      chk("b2b2_rows", 32'(rows), 32'({3'b111, ~c}));
    end

    // Reset during BOUNCE_OUT: key 5 (row 1, col 1), hold 3
    @(negedge clk);
    cols = 4'b1101; ck = 4'h5; ch = 16'd3; cv = 1'b1;
    @(posedge clk); #1;
    n = cyc; cv = 0;
    q_done.push_back(n + 35);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      e = 4'hF;
      e[1] = ~cexp(k, 3, m_lfsr[0]);
      chk("mrst_rows", 32'(rows), 32'(e));
    end
    rst = 1'b0;
    q_done.delete();
    #1;
    chk("mrst_rows_now", 32'(rows), 32'hF);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(cr), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(cr), 32'd1);
    chk("post_rst_rows", 32'(rows), 32'hF);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q_done.size()), 32'd0);
    chk("sb0_empty", 32'(q_done0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
